// File: rtl/bus_arbiter_pkg.sv
// Shared constants and state encoding for the four-master round-robin bus arbiter.
package bus_arbiter_pkg;

    localparam int NUM_MASTERS = 4;
    localparam int IDX_W       = 2;
    localparam int ADDR_W      = 30;
    localparam int DATA_W      = 32;

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } arb_state_e;

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// Combinational round-robin winner search: first requester at or above start, wrapping,
// ignoring any master flagged in the exclude mask.
module rr_pick
    import bus_arbiter_pkg::*;
(
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [IDX_W-1:0]       start,
    input  logic [NUM_MASTERS-1:0] excl,
    output logic [IDX_W-1:0]       idx,
    output logic                   vld
);

    logic [IDX_W-1:0] pos;

    // Walk from the farthest offset down so the nearest eligible master is written last.
    always_comb begin
        idx = '0;
        vld = 1'b0;
        pos = '0;
        for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
            pos = start + IDX_W'(k);
            if (req[pos] && !excl[pos]) begin
                idx = pos;
                vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Four-master round-robin bus arbiter with a registered one-hot grant and shared-bus mux.
// Optional ownership timeout is built when BUS_ARB_TIMEOUT_EN is defined.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_MASTERS-1:0]        m_req,
    output logic [NUM_MASTERS-1:0]        m_grnt,
    input  logic [NUM_MASTERS*ADDR_W-1:0] m_addr,
    input  logic [NUM_MASTERS-1:0]        m_as,
    input  logic [NUM_MASTERS-1:0]        m_rw,
    input  logic [NUM_MASTERS*DATA_W-1:0] m_wr_data,
    output logic [NUM_MASTERS-1:0]        m_rdy,
    output logic [DATA_W-1:0]             m_rd_data,
    output logic [ADDR_W-1:0]             s_addr,
    output logic                          s_as,
    output logic                          s_rw,
    output logic [DATA_W-1:0]             s_wr_data,
    input  logic                          s_rdy,
    input  logic [DATA_W-1:0]             s_rd_data,
    output logic [IDX_W-1:0]              owner,
    output logic                          owner_vld,
    output logic                          timeout_err
);

    if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_bad_timeout
        $error("bus_arbiter: TIMEOUT_CYC must be within 1..255");
    end

    arb_state_e             state_q, state_d;
    logic [IDX_W-1:0]       rr_q, rr_d;
    logic [IDX_W-1:0]       owner_q, owner_d;
    logic [NUM_MASTERS-1:0] grnt_q, grnt_d;
    logic                   owner_vld_q, owner_vld_d;
    logic                   timeout_err_q, timeout_err_d;

    logic                   owner_req;
    logic                   timeout_hit;
    logic [NUM_MASTERS-1:0] excl;
    logic [IDX_W-1:0]       pick_idx;
    logic                   pick_vld;

    assign owner_req = m_req[owner_q];
    assign excl      = (state_q == OWNED) ? (NUM_MASTERS'(1) << owner_q) : '0;

`ifdef BUS_ARB_TIMEOUT_EN
    logic [7:0] cnt_q, cnt_d;

    assign timeout_hit = (state_q == OWNED) && owner_req && (cnt_q == 8'(TIMEOUT_CYC - 1));

    always_comb begin
        if (grnt_d != grnt_q) begin
            cnt_d = '0;
        end else if (state_q == OWNED) begin
            cnt_d = cnt_q + 8'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    rr_pick u_rr_pick (
        .req   (m_req),
        .start (rr_q),
        .excl  (excl),
        .idx   (pick_idx),
        .vld   (pick_vld)
    );

    always_comb begin
        state_d       = state_q;
        rr_d          = rr_q;
        owner_d       = owner_q;
        grnt_d        = grnt_q;
        owner_vld_d   = owner_vld_q;
        timeout_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    state_d     = OWNED;
                    grnt_d      = NUM_MASTERS'(1) << pick_idx;
                    owner_d     = pick_idx;
                    owner_vld_d = 1'b1;
                    rr_d        = pick_idx + IDX_W'(1);
                end
            end
            OWNED: begin
                if (!owner_req || timeout_hit) begin
                    timeout_err_d = timeout_hit;
                    // A timed-out master moves the pointer past itself even when another master wins.
                    if (timeout_hit) begin
                        rr_d = owner_q + IDX_W'(1);
                    end else if (pick_vld) begin
                        rr_d = pick_idx + IDX_W'(1);
                    end
                    if (pick_vld) begin
                        grnt_d  = NUM_MASTERS'(1) << pick_idx;
                        owner_d = pick_idx;
                    end else begin
                        state_d     = IDLE;
                        grnt_d      = '0;
                        owner_d     = '0;
                        owner_vld_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d     = IDLE;
                grnt_d      = '0;
                owner_d     = '0;
                owner_vld_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            rr_q          <= '0;
            owner_q       <= '0;
            grnt_q        <= '0;
            owner_vld_q   <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            rr_q          <= rr_d;
            owner_q       <= owner_d;
            grnt_q        <= grnt_d;
            owner_vld_q   <= owner_vld_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    always_comb begin
        s_addr    = '0;
        s_as      = 1'b0;
        s_rw      = 1'b0;
        s_wr_data = '0;
        if (owner_vld_q) begin
            s_addr    = m_addr[owner_q*ADDR_W +: ADDR_W];
            s_as      = m_as[owner_q];
            s_rw      = m_rw[owner_q];
            s_wr_data = m_wr_data[owner_q*DATA_W +: DATA_W];
        end
    end

    assign m_grnt      = grnt_q;
    assign owner       = owner_q;
    assign owner_vld   = owner_vld_q;
    assign timeout_err = timeout_err_q;
    assign m_rdy       = {NUM_MASTERS{s_rdy}} & grnt_q;
    assign m_rd_data   = s_rd_data;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed scoreboard bench for bus_arbiter: each step pushes the expected arbiter state,
// then pops and compares it one clock later, along with the shared-bus and ready outputs.
module tb_bus_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   m_req;
    logic [3:0]   m_grnt;
    logic [119:0] m_addr;
    logic [3:0]   m_as;
    logic [3:0]   m_rw;
    logic [127:0] m_wr_data;
    logic [3:0]   m_rdy;
    logic [31:0]  m_rd_data;
    logic [29:0]  s_addr;
    logic         s_as;
    logic         s_rw;
    logic [31:0]  s_wr_data;
    logic         s_rdy;
    logic [31:0]  s_rd_data;
    logic [1:0]   owner;
    logic         owner_vld;
    logic         timeout_err;

    typedef struct packed {
        logic [3:0] grnt;
        logic [1:0] owner;
        logic       vld;
        logic       terr;
    } exp_t;

    exp_t        sb_q[$];
    int          vectors = 0;
    int          miscompares = 0;
    logic [29:0] addr_tab [4];
    logic [31:0] data_tab [4];
    logic [3:0]  as_bits = 4'b1011;
    logic [3:0]  rw_bits = 4'b0110;

    bus_arbiter #(.TIMEOUT_CYC(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .m_req       (m_req),
        .m_grnt      (m_grnt),
        .m_addr      (m_addr),
        .m_as        (m_as),
        .m_rw        (m_rw),
        .m_wr_data   (m_wr_data),
        .m_rdy       (m_rdy),
        .m_rd_data   (m_rd_data),
        .s_addr      (s_addr),
        .s_as        (s_as),
        .s_rw        (s_rw),
        .s_wr_data   (s_wr_data),
        .s_rdy       (s_rdy),
        .s_rd_data   (s_rd_data),
        .owner       (owner),
        .owner_vld   (owner_vld),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Pops the oldest expectation and checks registered state plus the owner-driven bus.
    task automatic checkOutput();
        exp_t e;
        if (sb_q.size() == 0) begin
            vectors++;
            miscompares++;
            $error("[TB] FAIL scoreboard_empty observed=0 expected=1");
            return;
        end
        e = sb_q.pop_front();
        checkVal("m_grnt", 32'(m_grnt), 32'(e.grnt));
        checkVal("owner", 32'(owner), 32'(e.owner));
        checkVal("owner_vld", 32'(owner_vld), 32'(e.vld));
        checkVal("timeout_err", 32'(timeout_err), 32'(e.terr));
        checkVal("s_addr", 32'(s_addr), e.vld ? 32'(addr_tab[e.owner]) : 32'h0);
        checkVal("s_as", 32'(s_as), e.vld ? 32'(as_bits[e.owner]) : 32'h0);
        checkVal("s_rw", 32'(s_rw), e.vld ? 32'(rw_bits[e.owner]) : 32'h0);
        checkVal("s_wr_data", s_wr_data, e.vld ? data_tab[e.owner] : 32'h0);
        checkVal("m_rdy", 32'(m_rdy), s_rdy ? 32'(e.grnt) : 32'h0);
    endtask

    // Drives one cycle of reset/request, records what the arbiter must show after the edge.
    task automatic applyStimulus(input logic r, input logic [3:0] req, input logic [3:0] eg,
                                 input logic [1:0] eo, input logic ev, input logic et);
        rst   = r;
        m_req = req;
        sb_q.push_back('{grnt: eg, owner: eo, vld: ev, terr: et});
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    initial begin
        rst       = 1'b1;
        m_req     = '0;
        s_rdy     = 1'b0;
        s_rd_data = '0;
        m_as      = as_bits;
        m_rw      = rw_bits;
        for (int i = 0; i < 4; i++) begin
            addr_tab[i] = 30'h1234_5670 + 30'(i * 32'h0111_1111);
            data_tab[i] = 32'hCAFE_0000 + 32'(i * 32'h0101);
            m_addr[i*30 +: 30]    = addr_tab[i];
            m_wr_data[i*32 +: 32] = data_tab[i];
        end

        // Reset state and quiet idle.
        applyStimulus(1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);

        // Simultaneous 0 and 2 from rr=0: master 0 wins and holds; release hands to 2 without a gap.
        applyStimulus(1'b0, 4'b0101, 4'b0001, 2'd0, 1'b1, 1'b0);
        applyStimulus(1'b0, 4'b0101, 4'b0001, 2'd0, 1'b1, 1'b0);
        applyStimulus(1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0);
        applyStimulus(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);

        // Master 1 owns; slave ready and read data reach only master 1.
        applyStimulus(1'b0, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0);
        s_rdy     = 1'b1;
        s_rd_data = 32'hDEAD_BEEF;
        #1;
        checkVal("m_rdy_owner1", 32'(m_rdy), 32'h0000_0002);
        checkVal("m_rd_data", m_rd_data, 32'hDEAD_BEEF);
        applyStimulus(1'b0, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0);
        s_rdy     = 1'b0;
        s_rd_data = '0;

        // Back to idle with rr=2, then 4'b1011: master 3 wins; reset while 3 owns clears everything.
        applyStimulus(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 4'b1011, 4'b1000, 2'd3, 1'b1, 1'b0);
        applyStimulus(1'b1, 4'b1011, 4'b0000, 2'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);

        // All four request; each owner releases after three cycles: order 0, 1, 2, 3, 0.
        for (int m = 0; m < 4; m++) begin
            for (int c = 0; c < 3; c++) begin
                applyStimulus(1'b0, (c == 0 && m != 0) ? (4'b1111 & ~(4'b0001 << (m - 1))) : 4'b1111,
                              4'b0001 << m, 2'(m), 1'b1, 1'b0);
            end
        end
        applyStimulus(1'b0, 4'b0111, 4'b0001, 2'd0, 1'b1, 1'b0);
        applyStimulus(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);

        // Master 0 holds while master 1 waits.
        applyStimulus(1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
        for (int c = 0; c < 4; c++) begin
            applyStimulus(1'b0, 4'b0011, 4'b0001, 2'd0, 1'b1, 1'b0);
        end
`ifdef BUS_ARB_TIMEOUT_EN
        applyStimulus(1'b0, 4'b0011, 4'b0010, 2'd1, 1'b1, 1'b1);
        applyStimulus(1'b0, 4'b0011, 4'b0010, 2'd1, 1'b1, 1'b0);
`else
        applyStimulus(1'b0, 4'b0011, 4'b0001, 2'd0, 1'b1, 1'b0);
        applyStimulus(1'b0, 4'b0011, 4'b0001, 2'd0, 1'b1, 1'b0);
`endif
        applyStimulus(1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
